// File: rtl/instruction_fetch.sv
// Instruction fetch unit: sequences one instruction at a time from a
// synchronous-read instruction memory (ISSUE -> WAIT -> HOLD), holds it for the
// datapath until advance, and traps illegal fetch addresses in a sticky FAULT.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        advance,
    input  logic        redirect,
    input  logic [31:0] branch_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic        fault
);

    localparam int unsigned XLEN        = 32;
    localparam logic [XLEN-1:0] MEM_LIM = XLEN'(MEM_WORDS);

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            valid_q, valid_d;
    logic            fault_q, fault_d;

    logic [XLEN:0]   seq_sum;
    logic [XLEN-1:0] next_pc;
    logic            next_ok;

    // A fetch address is legal when word aligned and inside the memory.
    function automatic logic addr_legal(input logic [XLEN-1:0] a);
        return (a[1:0] == 2'b00) && ({2'b00, a[XLEN-1:2]} < MEM_LIM);
    endfunction

    // Sequential successor with carry so a 32-bit wrap is seen as illegal.
    always_comb begin
        seq_sum = {1'b0, pc_q} + (XLEN+1)'(4);
        if (redirect) begin
            next_pc = branch_target;
            next_ok = addr_legal(branch_target);
        end else begin
            next_pc = seq_sum[XLEN-1:0];
            next_ok = !seq_sum[XLEN] && addr_legal(seq_sum[XLEN-1:0]);
        end
    end

    // Next-state and register updates for the fetch sequencer.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        fault_d = fault_q;
        case (state_q)
            ST_ISSUE: begin
                // Only an illegal RESET_PC can reach ISSUE with a bad address.
                if (addr_legal(pc_q)) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                    valid_d = 1'b0;
                end
            end
            ST_WAIT: begin
                instr_d = imem_instr;
                valid_d = 1'b1;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (advance) begin
                    if (next_ok) begin
                        pc_d    = next_pc;
                        valid_d = 1'b0;
                        state_d = ST_ISSUE;
                    end else begin
                        // pc and instruction kept to identify the faulting fetch.
                        valid_d = 1'b0;
                        fault_d = 1'b1;
                        state_d = ST_FAULT;
                    end
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_ISSUE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_ISSUE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

    assign imem_addr   = {2'b00, pc_q[XLEN-1:2]};
    assign pc_plus4    = seq_sum[XLEN-1:0];
    assign pc          = pc_q;
    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: directed fetch/branch/fault/reset sequences,
// with a scoreboard of expected (pc, instruction, arrival cycle) per fetch.
module tb_instruction_fetch;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        advance;
    logic        redirect;
    logic [31:0] branch_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        fault;

    // Second instance with a misaligned reset pc.
    logic [31:0] imem_addr2;
    logic [31:0] imem_instr2;
    logic [31:0] pc2;
    logic [31:0] pc_plus4_2;
    logic [31:0] instruction2;
    logic        instr_valid2;
    logic        fault2;

    logic [31:0] mem [256];
    exp_t        sb [$];
    logic [31:0] cyc = 32'd0;
    int          checks = 0;
    int          errors = 0;
    logic        prev_v = 1'b0;

    instruction_fetch #(.RESET_PC(32'h0000_0000), .MEM_WORDS(256)) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_addr    (imem_addr),
        .imem_instr   (imem_instr),
        .advance      (advance),
        .redirect     (redirect),
        .branch_target(branch_target),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .instruction  (instruction),
        .instr_valid  (instr_valid),
        .fault        (fault)
    );

    instruction_fetch #(.RESET_PC(32'h0000_0002), .MEM_WORDS(256)) dut_bad (
        .clk          (clk),
        .reset        (reset),
        .imem_addr    (imem_addr2),
        .imem_instr   (imem_instr2),
        .advance      (advance),
        .redirect     (redirect),
        .branch_target(branch_target),
        .pc           (pc2),
        .pc_plus4     (pc_plus4_2),
        .instruction  (instruction2),
        .instr_valid  (instr_valid2),
        .fault        (fault2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    // Synchronous-read instruction memory model.
    always @(posedge clk) imem_instr <= mem[imem_addr[7:0]];

    assign imem_instr2 = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic rnd_in();
        advance       = 1'($urandom);
        redirect      = 1'($urandom);
        branch_target = $urandom;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!instr_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_valid_timeout"}, 32'(instr_valid), 32'd1);
    endtask

    // Assert reset for one edge, check reset state, release and fetch word 0.
    task automatic reset_fetch(input string name);
        reset = 1'b1;
        rnd_in();
        @(negedge clk);
        chk({name, "_rst_pc"}, pc, 32'h0);
        chk({name, "_rst_valid"}, 32'(instr_valid), 32'd0);
        chk({name, "_rst_fault"}, 32'(fault), 32'd0);
        chk({name, "_rst_instr"}, instruction, 32'h0);
        chk({name, "_rst_addr"}, imem_addr, 32'h0);
        chk({name, "_bad_rst_fault"}, 32'(fault2), 32'd0);
        chk({name, "_bad_rst_pc"}, pc2, 32'h2);
        reset = 1'b0;
        sb.push_back('{pc: 32'h0, instr: mem[0], cyc: cyc + 32'd2});
        rnd_in();
        @(negedge clk);
        chk({name, "_wait_pc"}, pc, 32'h0);
        chk({name, "_wait_addr"}, imem_addr, 32'h0);
        chk({name, "_wait_valid"}, 32'(instr_valid), 32'd0);
        chk({name, "_bad_fault"}, 32'(fault2), 32'd1);
        chk({name, "_bad_valid"}, 32'(instr_valid2), 32'd0);
        chk({name, "_bad_pc"}, pc2, 32'h2);
        chk({name, "_bad_addr"}, imem_addr2, 32'h0);
        chk({name, "_bad_pc4"}, pc_plus4_2, 32'h6);
        chk({name, "_bad_instr"}, instruction2, 32'h0);
        rnd_in();
        @(negedge clk);
        advance  = 1'b0;
        redirect = 1'b0;
        wait_valid(name);
    endtask

    // From HOLD: advance to a legal pc and expect its word after the fetch.
    task automatic adv_fetch(input string name, input logic rd, input logic [31:0] tgt,
                             input logic [31:0] epc, input logic [31:0] ein, input bit hold);
        advance       = 1'b1;
        redirect      = rd;
        branch_target = tgt;
        sb.push_back('{pc: epc, instr: ein, cyc: cyc + 32'd3});
        @(negedge clk);
        chk({name, "_issue_pc"}, pc, epc);
        chk({name, "_issue_addr"}, imem_addr, {2'b00, epc[31:2]});
        chk({name, "_issue_valid"}, 32'(instr_valid), 32'd0);
        rnd_in();
        if (hold) advance = 1'b1;
        @(negedge clk);
        chk({name, "_wait_pc"}, pc, epc);
        chk({name, "_wait_addr"}, imem_addr, {2'b00, epc[31:2]});
        rnd_in();
        if (hold) advance = 1'b1;
        @(negedge clk);
        advance  = 1'b0;
        redirect = 1'b0;
        wait_valid(name);
    endtask

    // From HOLD: advance to an illegal pc; expect a sticky fault with state frozen.
    task automatic fault_pulse(input string name, input logic rd, input logic [31:0] tgt,
                               input logic [31:0] epc, input logic [31:0] ein);
        advance       = 1'b1;
        redirect      = rd;
        branch_target = tgt;
        @(negedge clk);
        chk({name, "_fault"}, 32'(fault), 32'd1);
        chk({name, "_valid"}, 32'(instr_valid), 32'd0);
        chk({name, "_pc"}, pc, epc);
        chk({name, "_instr"}, instruction, ein);
        for (int i = 0; i < 3; i++) begin
            advance       = 1'b1;
            redirect      = 1'($urandom);
            branch_target = 32'h4 * 32'(i);
            @(negedge clk);
            chk({name, "_sticky_fault"}, 32'(fault), 32'd1);
            chk({name, "_sticky_pc"}, pc, epc);
            chk({name, "_sticky_valid"}, 32'(instr_valid), 32'd0);
        end
        advance  = 1'b0;
        redirect = 1'b0;
    endtask

    // Scoreboard monitor: every rising instr_valid must match the oldest expectation.
    always @(negedge clk) begin
        if (instr_valid && !prev_v) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got pc %h instr %h with no fetch outstanding", pc, instruction);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (pc !== e.pc || instruction !== e.instr || cyc !== e.cyc) begin
                    errors++;
                    $display("FAIL fetch: got pc %h instr %h cycle %0d expected pc %h instr %h cycle %0d",
                             pc, instruction, cyc, e.pc, e.instr, e.cyc);
                end
            end
        end
        prev_v = instr_valid;
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | 32'(i);
        mem[0] = 32'h8C01_0020;
        mem[1] = 32'h8C02_0020;
        mem[2] = 32'h8C03_0020;
        reset         = 1'b1;
        advance       = 1'b0;
        redirect      = 1'b0;
        branch_target = 32'h0;
        repeat (2) @(negedge clk);

        // Straight-line fetch with advance held high.
        reset_fetch("boot");
        adv_fetch("seq4", 1'b0, 32'hDEAD_BEE0, 32'h4, 32'h8C02_0020, 1'b1);
        adv_fetch("seq8", 1'b0, 32'h0000_0040, 32'h8, 32'h8C03_0020, 1'b1);

        // Hold stays put without advance, even with redirect set.
        redirect      = 1'b1;
        branch_target = 32'h0000_0010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_pc", pc, 32'h8);
            chk("hold_instr", instruction, 32'h8C03_0020);
            chk("hold_valid", 32'(instr_valid), 32'd1);
            chk("hold_pc4", pc_plus4, 32'hC);
        end
        redirect = 1'b0;

        // Branch back to 0, then to the last two words and step off the end.
        adv_fetch("br0", 1'b1, 32'h0, 32'h0, 32'h8C01_0020, 1'b0);
        adv_fetch("br3f8", 1'b1, 32'h3F8, 32'h3F8, mem[254], 1'b0);
        adv_fetch("seq3fc", 1'b0, 32'h0, 32'h3FC, mem[255], 1'b0);
        chk("last_pc4", pc_plus4, 32'h400);
        fault_pulse("endmem", 1'b0, 32'h0, 32'h3FC, mem[255]);

        // Reset out of FAULT, then misaligned branch target.
        reset_fetch("rst_fault");
        adv_fetch("seq4b", 1'b0, 32'h0, 32'h4, 32'h8C02_0020, 1'b0);
        fault_pulse("misalign", 1'b1, 32'h6, 32'h4, 32'h8C02_0020);

        // Out-of-range branch target.
        reset_fetch("rst_fault2");
        fault_pulse("range", 1'b1, 32'h400, 32'h0, 32'h8C01_0020);

        // Reset mid-fetch: the partially fetched word must never show up.
        reset_fetch("rst_fault3");
        advance  = 1'b1;
        redirect = 1'b0;
        @(negedge clk);
        chk("abort_issue_pc", pc, 32'h4);
        advance = 1'b0;
        @(negedge clk);
        chk("abort_wait_valid", 32'(instr_valid), 32'd0);
        reset_fetch("rst_wait");
        adv_fetch("br10", 1'b1, 32'h10, 32'h10, mem[4], 1'b0);

        repeat (4) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
